// File: rtl/layer_vec_tx.sv
// Ping-pong vector buffer between a host writer and a streaming layer input.
// Optional sticky write-overflow flag: define LAYER_VEC_TX_OVF_EN to add port ovf.
module layer_vec_tx #(
  parameter int T = 16,
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic signed [T-1:0] wr_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [T-1:0] data_out,
  output logic                m_last,
  output logic [1:0]          full_banks
`ifdef LAYER_VEC_TX_OVF_EN
  ,
  output logic                ovf
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // source holds data/valid (and m_last) stable while valid && !ready.

  logic signed [T-1:0] mem_q [2][N];

  logic [1:0]          full_q, full_d;
  logic                fill_bank_q, fill_bank_d;
  logic                drain_bank_q, drain_bank_d;
  logic [IW-1:0]       fill_idx_q, fill_idx_d;
  logic [IW-1:0]       drain_idx_q, drain_idx_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;
  logic signed [T-1:0] data_q, data_d;

  logic wr_fire, rd_fire, fill_done, drain_done, other_bank;

  assign wr_ready   = !full_q[fill_bank_q];
  assign wr_fire    = wr_valid && wr_ready;
  assign rd_fire    = m_valid_q && m_ready;
  assign fill_done  = wr_fire && (fill_idx_q == LAST_IDX);
  assign drain_done = rd_fire && (drain_idx_q == LAST_IDX);
  assign other_bank = ~drain_bank_q;

  always_comb begin
    full_d       = full_q;
    fill_bank_d  = fill_bank_q;
    fill_idx_d   = fill_idx_q;
    drain_bank_d = drain_bank_q;
    drain_idx_d  = drain_idx_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    data_d       = data_q;

    if (wr_fire) begin
      if (fill_done) begin
        full_d[fill_bank_q] = 1'b1;
        fill_idx_d          = '0;
        fill_bank_d         = ~fill_bank_q;
      end else begin
        fill_idx_d = fill_idx_q + IW'(1);
      end
    end

    // A completing fill is never the bank being freed, so both updates apply.
    if (drain_done) begin
      full_d[drain_bank_q] = 1'b0;
    end

    if (!m_valid_q) begin
      if (full_q[drain_bank_q]) begin
        m_valid_d   = 1'b1;
        data_d      = mem_q[drain_bank_q][0];
        m_last_d    = 1'b0;
        drain_idx_d = '0;
      end
    end else if (m_ready) begin
      if (drain_idx_q == LAST_IDX) begin
        drain_bank_d = other_bank;
        drain_idx_d  = '0;
        m_last_d     = 1'b0;
        if (full_q[other_bank]) begin
          m_valid_d = 1'b1;
          data_d    = mem_q[other_bank][0];
        end else begin
          m_valid_d = 1'b0;
        end
      end else begin
        drain_idx_d = drain_idx_q + IW'(1);
        data_d      = mem_q[drain_bank_q][drain_idx_q + IW'(1)];
        m_last_d    = ((drain_idx_q + IW'(1)) == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[fill_bank_q][fill_idx_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q       <= '0;
      fill_bank_q  <= 1'b0;
      fill_idx_q   <= '0;
      drain_bank_q <= 1'b0;
      drain_idx_q  <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      data_q       <= '0;
    end else begin
      full_q       <= full_d;
      fill_bank_q  <= fill_bank_d;
      fill_idx_q   <= fill_idx_d;
      drain_bank_q <= drain_bank_d;
      drain_idx_q  <= drain_idx_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      data_q       <= data_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign data_out   = data_q;
  assign full_banks = {1'b0, full_q[0]} + {1'b0, full_q[1]};

`ifdef LAYER_VEC_TX_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (wr_valid && !wr_ready) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  // Writes offered while wr_ready is low never reach wr_fire and are dropped.
`endif

endmodule

// File: tb/tb_layer_vec_tx.sv
// Directed bench for layer_vec_tx: vector table for the basic stream plus
// hand-written sequences for backpressure, reset, and bank-collision cases.
module tb_layer_vec_tx;
  localparam int T = 16;
  localparam int N = 8;

  logic                clk = 1'b0;
  logic                reset;
  logic                wr_valid;
  logic                wr_ready;
  logic signed [T-1:0] wr_data;
  logic                m_valid;
  logic                m_ready;
  logic signed [T-1:0] data_out;
  logic                m_last;
  logic [1:0]          full_banks;
`ifdef LAYER_VEC_TX_OVF_EN
  logic                ovf;
`endif

  layer_vec_tx #(.T(T), .N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .data_out   (data_out),
    .m_last     (m_last),
    .full_banks (full_banks)
`ifdef LAYER_VEC_TX_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [T-1:0] recv_q[$];
  int           recv_cyc[$];
  logic [T-1:0] exp_q[$];
  int           cyc = 0;

  always @(posedge clk) begin
    if (reset && m_valid && m_ready) begin
      recv_q.push_back(data_out);
      recv_cyc.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  typedef struct {
    logic         wv;
    logic [T-1:0] wd;
    logic         mr;
    logic         exp_valid;
    logic         chk_data;
    logic [T-1:0] exp_data;
    logic         exp_last;
    logic [1:0]   exp_full;
    logic         exp_wr_ready;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    m_ready  = 1'b0;
    tick(2);
    reset = 1'b1;
    recv_q.delete();
    recv_cyc.delete();
  endtask

  task automatic write_vec(input int base, input logic mr);
    for (int i = 0; i < N; i++) begin
      wr_valid = 1'b1;
      wr_data  = T'(base + i);
      m_ready  = mr;
      tick(1);
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_recv(input int n, input int budget);
    int k = 0;
    while (recv_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check("wait_recv count", recv_q.size(), n);
  endtask

  task automatic compare_recv(input string name, input int base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(T'(base + i));
    check({name, " size"}, recv_q.size(), exp_q.size());
    for (int i = 0; i < n && i < recv_q.size(); i++) begin
      check({name, " data"}, recv_q[i], exp_q[i]);
    end
  endtask

  initial begin
    // Basic stream table: row c is driven, one edge passes, outputs checked.
    for (int c = 1; c <= 17; c++) begin
      tbl[c-1].wv           = (c <= 8);
      tbl[c-1].wd           = T'(c);
      tbl[c-1].mr           = 1'b1;
      tbl[c-1].exp_valid    = (c >= 9 && c <= 16);
      tbl[c-1].chk_data     = (c <= 16);
      tbl[c-1].exp_data     = (c >= 9) ? T'(c - 8) : '0;
      tbl[c-1].exp_last     = (c == 16);
      tbl[c-1].exp_full     = (c >= 8 && c <= 16) ? 2'd1 : 2'd0;
      tbl[c-1].exp_wr_ready = 1'b1;
    end

    // Reset state, checked asynchronously before any clock edge.
    reset = 1'b0; wr_valid = 1'b0; wr_data = '0; m_ready = 1'b0;
    #2;
    check("reset m_valid", m_valid, 0);
    check("reset m_last", m_last, 0);
    check("reset data_out", data_out, 0);
    check("reset full_banks", full_banks, 0);
`ifdef LAYER_VEC_TX_OVF_EN
    check("reset ovf", ovf, 0);
`endif
    do_reset();
    check("wr_ready after reset", wr_ready, 1);

    // Basic back-to-back vector with m_ready held high.
    for (int r = 0; r < 17; r++) begin
      wr_valid = tbl[r].wv;
      wr_data  = tbl[r].wd;
      m_ready  = tbl[r].mr;
      tick(1);
      check($sformatf("tbl%0d m_valid", r), m_valid, tbl[r].exp_valid);
      if (tbl[r].chk_data) check($sformatf("tbl%0d data_out", r), data_out, tbl[r].exp_data);
      check($sformatf("tbl%0d m_last", r), m_last, tbl[r].exp_last);
      check($sformatf("tbl%0d full_banks", r), full_banks, tbl[r].exp_full);
      check($sformatf("tbl%0d wr_ready", r), wr_ready, tbl[r].exp_wr_ready);
    end
    wr_valid = 1'b0;
    compare_recv("basic", 1, 8);

    // Two vectors under backpressure, then a gapless 16-word drain.
    do_reset();
    write_vec(1, 1'b0);
    write_vec(9, 1'b0);
    check("bp full_banks", full_banks, 2);
    check("bp wr_ready", wr_ready, 0);
    check("bp m_valid", m_valid, 1);
    check("bp data_out", data_out, 1);
    wr_valid = 1'b1; wr_data = 16'sd99;
    tick(1);
    wr_valid = 1'b0;
`ifdef LAYER_VEC_TX_OVF_EN
    check("ovf set", ovf, 1);
`endif
    check("bp still full", full_banks, 2);
    check("bp data held", data_out, 1);
    m_ready = 1'b1;
    wait_recv(16, 40);
    compare_recv("bp", 1, 16);
    if (recv_cyc.size() == 16) check("bp no gap", recv_cyc[15] - recv_cyc[0], 15);
    tick(1);
    check("bp drained full_banks", full_banks, 0);
    check("bp drained wr_ready", wr_ready, 1);
`ifdef LAYER_VEC_TX_OVF_EN
    check("ovf sticky", ovf, 1);
`endif

    // Alternating m_ready: every element held until accepted.
    do_reset();
    write_vec(1, 1'b0);
    tick(1);
    check("tog loaded m_valid", m_valid, 1);
    check("tog loaded data", data_out, 1);
    for (int k = 0; k < 40 && recv_q.size() < 8; k++) begin
      logic         mr;
      logic         bv;
      logic [T-1:0] bd;
      mr = (k % 2 == 0);
      m_ready = mr;
      bv = m_valid;
      bd = data_out;
      tick(1);
      if (!mr && bv) begin
        check("tog hold valid", m_valid, 1);
        check("tog hold data", data_out, bd);
      end
    end
    m_ready = 1'b0;
    compare_recv("tog", 1, 8);
    check("tog full_banks", full_banks, 0);

    // Reset in the middle of a vector, then a fresh vector.
    do_reset();
    write_vec(1, 1'b1);
    wait_recv(5, 30);
    reset = 1'b0;
    #1;
    check("midrst m_valid", m_valid, 0);
    check("midrst m_last", m_last, 0);
    check("midrst data_out", data_out, 0);
    check("midrst full_banks", full_banks, 0);
    tick(2);
    reset = 1'b1;
    recv_q.delete();
    recv_cyc.delete();
    check("midrst wr_ready", wr_ready, 1);
    write_vec(20, 1'b1);
    wait_recv(8, 30);
    compare_recv("midrst", 20, 8);

    // Bank 1 completes on the same edge bank 0 sends its last element.
    do_reset();
    write_vec(1, 1'b0);
    for (int i = 9; i <= 15; i++) begin
      wr_valid = 1'b1;
      wr_data  = T'(i);
      tick(1);
    end
    wr_valid = 1'b0;
    check("col pre m_valid", m_valid, 1);
    check("col pre data", data_out, 1);
    check("col pre full", full_banks, 1);
    m_ready = 1'b1;
    tick(7);
    check("col last data", data_out, 8);
    check("col last m_last", m_last, 1);
    wr_valid = 1'b1; wr_data = 16'sd16;
    tick(1);
    wr_valid = 1'b0;
    check("col full_banks", full_banks, 1);
    check("col m_valid gap", m_valid, 0);
    check("col wr_ready", wr_ready, 1);
    tick(1);
    check("col next m_valid", m_valid, 1);
    check("col next data", data_out, 9);
    check("col next m_last", m_last, 0);
    wait_recv(16, 30);
    compare_recv("col", 1, 16);

    // Negative data passes through with sign intact.
    do_reset();
    write_vec(-4, 1'b1);
    wait_recv(8, 30);
    compare_recv("signed", -4, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/layer_vec_tx.md
LAYER_VEC_TX -- requirements
Module: layer_vec_tx

Interface
REQ-001 SHALL have parameter T, default 16, meaning data word width in bits.
REQ-002 SHALL have parameter N, default 8, meaning elements per input vector (N >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = asserted).
REQ-005 SHALL have port wr_valid  input  1  host offers one vector element.
REQ-006 SHALL have port wr_ready  output  1  block can accept a host element.
REQ-007 SHALL have port wr_data  input  T  signed host element.
REQ-008 SHALL have port m_valid  output  1  element valid toward the layer's s_valid.
REQ-009 SHALL have port m_ready  input  1  layer accepts element (the layer's s_ready).
REQ-010 SHALL have port data_out  output  T  signed element toward the layer's data_in.
REQ-011 SHALL have port m_last  output  1  high with the element of index N-1.
REQ-012 SHALL have port full_banks  output  2  number of committed, unsent vectors (0..2).

Function
REQ-013 SHALL hold two N-entry vector banks (ping-pong), each with a full flag; fill and drain alternate between bank 0 and bank 1, starting at bank 0.
REQ-014 SHALL compute wr_ready combinationally as 1 when the current fill bank is not full, else 0.
REQ-015 SHALL treat a host handshake as wr_valid && wr_ready, writing wr_data at fill index 0..N-1 in arrival order.
REQ-016 SHALL set the fill bank's full flag, reset the fill index to 0 and toggle the fill bank on the edge accepting index N-1.
REQ-017 SHALL, with the output register empty and the drain bank full, load element 0 into data_out and assert m_valid on the next rising edge.
REQ-018 SHALL treat a layer handshake as m_valid && m_ready; data_out, m_valid and m_last SHALL stay stable while m_valid && !m_ready.
REQ-019 SHALL, on a handshake of index k < N-1, present index k+1 on the following edge with no bubble.
REQ-020 SHALL, on the handshake of index N-1, clear that bank's full flag and toggle the drain bank; if the other bank is already full, present its element 0 on the same edge with no bubble; otherwise deassert m_valid.
REQ-021 SHALL, when a bank completes filling and the drain side frees a bank on the same edge, apply both updates, so full_banks is unchanged.
REQ-022 SHALL, with both banks full, hold wr_ready at 0; wr_ready SHALL rise in the cycle after the freeing handshake.
REQ-023 SHALL pass data unmodified: no arithmetic, sign preserved, width T.

Reset
REQ-024 SHALL, while reset is 0, force m_valid=0, m_last=0, data_out=0, full_banks=0, both full flags=0, fill and drain index=0, fill and drain bank=0, independent of clk.
REQ-025 SHALL discard any partially filled or partially sent vector on reset; memory contents need not be cleared.
REQ-026 SHALL make wr_ready=1 from the first cycle after reset deasserts.

Configuration
REQ-027 SHALL support macro LAYER_VEC_TX_OVF_EN; when defined, an extra output port ovf (1 bit) SHALL set sticky when wr_valid=1 && wr_ready=0, and clear only on reset.
REQ-028 SHALL, without LAYER_VEC_TX_OVF_EN, have no ovf port, and writes attempted while wr_ready=0 SHALL be silently ignored.

Verification
REQ-029 SHALL cover: after reset, write 1..8 back-to-back with m_ready=1 -> m_valid rises at the 2nd edge after the 8th write; data_out 1..8 on consecutive cycles; m_last only with 8; full_banks returns to 0.
REQ-030 SHALL cover: m_ready=0 while two vectors (1..8, 9..16) are written -> full_banks=2, wr_ready=0, data_out holds 1; then m_ready=1 -> 16 words, 1..16, with no gap between 8 and 9.
REQ-031 SHALL cover: m_ready toggling 1,0,1,0 during a vector -> each element is held until accepted; order 1..8 is intact; no duplicates.
REQ-032 SHALL cover: reset asserted after 5 of 8 elements are sent -> outputs are 0 immediately; a new vector 20..27 then streams correctly from index 0.
REQ-033 SHALL cover: with LAYER_VEC_TX_OVF_EN defined, wr_valid=1 while full_banks=2 -> ovf=1 and stays 1 after the banks drain; stored data is unchanged.
REQ-034 SHALL cover: the 8th write of bank 1 on the same edge as the m_last handshake of bank 0 -> full_banks stays 1; bank 1 element 0 appears on the next cycle.
